// File: rtl/uart_mem_loader_pkg.sv
// Shared encodings and constants for the UART program loader.
// Holds the protocol/bit-receiver state types and the frame length helper.
package uart_mem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CSUM_W        = 8;

    typedef enum logic [2:0] {
        P_HUNT = 3'd0,
        P_ADDR = 3'd1,
        P_LEN  = 3'd2,
        P_DATA = 3'd3,
        P_CSUM = 3'd4
    } proto_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A length byte of zero stands for a full 256-byte payload.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// Memory write port plus CPU/status handshake of the program loader.
// The loader drives it (master); memory mux and CPU observe it (slave).
interface uart_mem_loader_if;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       load_done;
    logic       load_err;

    modport master (
        output mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err
    );

    modport slave (
        input mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start/data/stop sampling.
// byte_valid/frm_err pulse one cycle after the stop-bit sample; no backpressure.
module uart_rx_byte
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frm_err
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic          rx_prev_q, rx_prev_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frm_err_q, frm_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        rx_meta_d    = rx_in;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        byte_valid_d = 1'b0;
        frm_err_d    = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit recheck rejects short low glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    state_d      = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frm_err_d    = !rx_sync_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            byte_valid_q <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            byte_valid_q <= byte_valid_d;
            frm_err_q    <= frm_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frm_err    = frm_err_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Serial program loader: parses SYNC/addr/len/data/csum frames into memory writes.
// mem_we one cycle after byte_valid; no backpressure, the memory port always accepts.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 120000
) (
    input  logic              CLK_12MHz,
    input  logic              RST,
    input  logic              rx_in,
    uart_mem_loader_if.master ld
);

    localparam int            IW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT_CLKS - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frm_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (CLK_12MHz),
        .rst        (RST),
        .rx_in      (rx_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frm_err    (frm_err)
    );

    proto_state_t      state_q, state_d;
    logic [7:0]        ptr_q, ptr_d;
    logic [CSUM_W-1:0] sum_q, sum_d;
    logic [8:0]        count_q, count_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              timeout;

    assign timeout = (state_q != P_HUNT) && (idle_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        count_d     = count_q;
        idle_d      = (state_q == P_HUNT) ? '0 : idle_q + 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        err_d       = err_q;

        // A byte arriving on the timeout cycle wins: the idle counter just restarts.
        if (byte_valid) begin
            idle_d = '0;
            case (state_q)
                P_HUNT: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d = P_ADDR;
                        hold_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                end
                P_ADDR: begin
                    ptr_d   = byte_data;
                    sum_d   = byte_data;
                    state_d = P_LEN;
                end
                P_LEN: begin
                    count_d = len_to_count(byte_data);
                    sum_d   = sum_q + byte_data;
                    state_d = P_DATA;
                end
                P_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = byte_data;
                    ptr_d       = ptr_q + 8'd1;
                    sum_d       = sum_q + byte_data;
                    count_d     = count_q - 9'd1;
                    if (count_q == 9'd1) state_d = P_CSUM;
                end
                P_CSUM: begin
                    if (byte_data == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = P_HUNT;
                end
                default: state_d = P_HUNT;
            endcase
        end else if ((state_q != P_HUNT) && (frm_err || timeout)) begin
            // Aborted loads keep the CPU held so a partial image never runs.
            err_d   = 1'b1;
            idle_d  = '0;
            state_d = P_HUNT;
        end
    end

    always_ff @(posedge CLK_12MHz or posedge RST) begin
        if (RST) begin
            state_q     <= P_HUNT;
            ptr_q       <= 8'd0;
            sum_q       <= '0;
            count_q     <= 9'd0;
            idle_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            idle_q      <= idle_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ld.mem_we    = mem_we_q;
    assign ld.mem_addr  = mem_addr_q;
    assign ld.mem_wdata = mem_wdata_q;
    assign ld.cpu_hold  = hold_q;
    assign ld.busy      = (state_q != P_HUNT);
    assign ld.load_done = done_q;
    assign ld.load_err  = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: table of whole frames plus hand-written corner sequences.
module tb_uart_mem_loader;

    localparam int CPB = 4;
    localparam int TO  = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_mem_loader_if ifc ();

    uart_mem_loader #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .CLK_12MHz (clk),
        .RST       (rst),
        .rx_in     (rx),
        .ld        (ifc)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Write/done monitor, sampled on the falling edge.
    logic [15:0] wr_q[$];
    int          done_cnt = 0;
    logic        clr_mon  = 1'b0;

    always @(negedge clk) begin
        if (clr_mon) begin
            wr_q.delete();
            done_cnt = 0;
        end else begin
            if (ifc.mem_we) wr_q.push_back({ifc.mem_addr, ifc.mem_wdata});
            if (ifc.load_done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge clk);
        #1 clr_mon = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata,
                ifc.cpu_hold, ifc.busy, ifc.load_done, ifc.load_err};
    endfunction

    typedef struct {
        int          n;
        logic [47:0] bytes;   // first byte in [47:40]
        int          exp_wr;
        int          exp_done;
        logic        exp_err;
        logic        exp_hold;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] cs;
        int         bad;

        vecs[0] = '{2, {8'h55, 8'hFF, 32'h0},                         0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{6, {8'hA5, 8'h10, 8'h02, 8'h37, 8'hF1, 8'h3A},    2, 1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{5, {8'hA5, 8'h00, 8'h01, 8'h70, 8'h00, 8'h00},    1, 0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{5, {8'hA5, 8'h00, 8'h01, 8'h70, 8'h71, 8'h00},    1, 1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset outputs", outs(), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            clear_mon();
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].bytes[47 - 8*i -: 8], 1'b1);
                if (i == 0 && vecs[v].bytes[47:40] == 8'hA5)
                    check($sformatf("v%0d hold/busy after sync", v),
                          {30'd0, ifc.cpu_hold, ifc.busy}, 32'd3);
            end
            repeat (8) @(negedge clk);
            check($sformatf("v%0d write count", v), wr_q.size(), vecs[v].exp_wr);
            for (int k = 0; k < vecs[v].exp_wr && k < wr_q.size(); k++)
                check($sformatf("v%0d write %0d", v, k), {16'd0, wr_q[k]},
                      {16'd0, vecs[v].bytes[39:32] + 8'(k), vecs[v].bytes[47 - 8*(3+k) -: 8]});
            check($sformatf("v%0d load_done pulses", v), done_cnt, vecs[v].exp_done);
            check($sformatf("v%0d load_err", v), {31'd0, ifc.load_err}, {31'd0, vecs[v].exp_err});
            check($sformatf("v%0d cpu_hold", v), {31'd0, ifc.cpu_hold}, {31'd0, vecs[v].exp_hold});
            check($sformatf("v%0d busy", v), {31'd0, ifc.busy}, {31'd0, vecs[v].exp_busy});
        end

        // len=0 (256 bytes) with address wrap FF->00
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'h00, 1'b1);
        cs = 8'hFE;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1'b1);
            cs = cs + 8'(i);
        end
        send_byte(cs, 1'b1);
        repeat (8) @(negedge clk);
        check("wrap write count", wr_q.size(), 256);
        bad = 0;
        for (int k = 0; k < wr_q.size(); k++)
            if (wr_q[k] !== {8'hFE + 8'(k), 8'(k)}) bad++;
        check("wrap write contents mismatches", bad, 0);
        check("wrap load_done", done_cnt, 1);
        check("wrap cpu_hold", {31'd0, ifc.cpu_hold}, 32'd0);

        // 1-cycle glitch between LEN and the data byte must not become a byte
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h12, 1'b1);
        send_byte(8'h53, 1'b1);
        repeat (8) @(negedge clk);
        check("glitch write count", wr_q.size(), 1);
        check("glitch write", {16'd0, wr_q[0]}, 32'h4012);
        check("glitch load_done", done_cnt, 1);

        // Stop bit driven low mid-frame
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h66, 1'b0);
        repeat (8) @(negedge clk);
        check("stop err load_err/busy/hold", {29'd0, ifc.load_err, ifc.busy, ifc.cpu_hold}, 32'b101);
        check("stop err write count", wr_q.size(), 0);

        // Idle timeout after the address byte
        clear_mon();
        send_byte(8'hA5, 1'b1);
        check("sync clears load_err", {31'd0, ifc.load_err}, 32'd0);
        send_byte(8'h20, 1'b1);
        check("busy before timeout", {31'd0, ifc.busy}, 32'd1);
        repeat (TO + 50) @(negedge clk);
        check("timeout load_err/busy/hold", {29'd0, ifc.load_err, ifc.busy, ifc.cpu_hold}, 32'b101);
        check("timeout write count", wr_q.size(), 0);

        // Reset during the 2nd data byte
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h60, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-frame reset outputs", outs(), 32'd0);
        check("writes before reset", wr_q.size(), 1);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("no write after reset", wr_q.size(), 1);
        clear_mon();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h60, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'hC9, 1'b1);
        repeat (8) @(negedge clk);
        check("reload write count", wr_q.size(), 3);
        check("reload last write", {16'd0, wr_q[wr_q.size() - 1]}, 32'h6233);
        check("reload load_done", done_cnt, 1);
        check("reload hold/err", {30'd0, ifc.cpu_hold, ifc.load_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
